// File: rtl/nn_wb_pkg.sv
// Shared definitions for the NN peripheral Wishbone responders:
// register offsets, STATUS bit positions and the bus FSM state type.
package nn_wb_pkg;

  localparam logic [31:0] OFF_DATA   = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_CTRL   = 32'h8;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_MSB = 15;

  localparam int CTRL_FLUSH = 0;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/nn_sync_fifo.sv
// Synchronous FIFO core: storage, pointers and fill count.
// Flush has priority over push and pop. Pops on empty and pushes on
// full are ignored. Read data is the entry at rptr, combinationally.
module nn_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rptr];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nn_output_fifo.sv
// Result-side buffer of the NN peripheral. The NN core pushes results
// over valid/ready; the Wishbone host pops them through a 3-register
// window (DATA, STATUS, CTRL).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a strobe to a decoded address
// ACK   | ack pulse for the access latched on entry; strobe ignored
module nn_output_fifo
  import nn_wb_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_valid,
  input  logic [31:0]            res_data,
  output logic                   res_ready,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic [31:0]            wbs_dat_o,
  output logic                   wbs_ack_o,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  wb_state_t   state;
  logic        underflow;
  logic        full;
  logic [31:0] fifo_rdata;
  logic        sel_data;
  logic        sel_status;
  logic        sel_ctrl;
  logic        req;
  logic        pop;
  logic        flush;
  logic [31:0] status_word;
  logic [31:0] rd_val;
  logic        unused_dat;

  assign unused_dat = ^wbs_dat_i[31:1];

  assign res_ready  = !full;
  assign sel_data   = (wbs_adr_i == BASE_ADDR + OFF_DATA);
  assign sel_status = (wbs_adr_i == BASE_ADDR + OFF_STATUS);
  assign sel_ctrl   = (wbs_adr_i == BASE_ADDR + OFF_CTRL);
  assign req        = (state == IDLE) && wbs_cyc_i && wbs_stb_i &&
                      (sel_data || sel_status || sel_ctrl);
  assign pop        = req && sel_data && !wbs_we_i;
  assign flush      = req && sel_ctrl && wbs_we_i && wbs_dat_i[CTRL_FLUSH];

  nn_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_valid && res_ready),
    .wdata (res_data),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // STATUS image and read-data select for the access being accepted.
  always_comb begin
    status_word = '0;
    status_word[ST_EMPTY]     = empty;
    status_word[ST_FULL]      = full;
    status_word[ST_UNDERFLOW] = underflow;
    status_word[ST_COUNT_MSB:ST_COUNT_LSB] = 8'(count);

    rd_val = '0;
    if (!wbs_we_i) begin
      if (sel_data && !empty) rd_val = fifo_rdata;
      else if (sel_status)    rd_val = status_word;
    end
  end

  // Bus FSM with registered ack/data and the sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= rd_val;
            if (pop && empty) begin
              underflow <= 1'b1;
            end else if (sel_status && !wbs_we_i) begin
              underflow <= 1'b0;
            end
          end
        end
        ACK: begin
          state     <= IDLE;
          wbs_ack_o <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          wbs_ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_output_fifo.sv
// Directed bench for nn_output_fifo: a table of single bus accesses
// with expected ack/data/count, then hand-written multi-cycle sequences.
module tb_nn_output_fifo;

  localparam logic [31:0] B = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        res_ready;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        empty;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  nn_output_fifo #(.DEPTH(8), .BASE_ADDR(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          npush;
    logic [31:0] pbase;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        exp_ack;
    logic        chk_dat;
    logic [31:0] exp_dat;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = base + 32'(i);
      @(posedge clk);
    end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  // One access: strobe from a negedge, sample ack/data one edge later,
  // then sample ack again one edge after that.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic ack1, output logic ack2);
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = wd;
    @(posedge clk);
    #1;
    ack1 = wbs_ack_o;
    rd   = wbs_dat_o;
    @(negedge clk);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_dat_i = '0;
    @(posedge clk);
    #1;
    ack2 = wbs_ack_o;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    logic a1, a2;
    bus(1'b0, adr, '0, rd, a1, a2);
    chk({nm, " ack"}, {31'b0, a1}, 32'h1);
    chk({nm, " data"}, rd, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic a1, a2;
    int k;
    int acks;
    logic r;

    vecs.push_back('{0, 0,            1'b0, B+4,  0,     1, 1, 32'h1,         0});
    vecs.push_back('{3, 32'hA5A5_0001, 1'b0, B,   0,     1, 1, 32'hA5A5_0001, 2});
    vecs.push_back('{0, 0,            1'b0, B,    0,     1, 1, 32'hA5A5_0002, 1});
    vecs.push_back('{0, 0,            1'b0, B,    0,     1, 1, 32'hA5A5_0003, 0});
    vecs.push_back('{0, 0,            1'b0, B+4,  0,     1, 1, 32'h1,         0});
    vecs.push_back('{0, 0,            1'b0, B,    0,     1, 1, 32'h0,         0});
    vecs.push_back('{0, 0,            1'b0, B+4,  0,     1, 1, 32'h5,         0});
    vecs.push_back('{0, 0,            1'b0, B+4,  0,     1, 1, 32'h1,         0});
    vecs.push_back('{2, 32'h10,        1'b0, B+8, 0,     1, 1, 32'h0,         2});
    vecs.push_back('{0, 0,            1'b1, B,    32'hFFFF, 1, 0, 32'h0,      2});
    vecs.push_back('{0, 0,            1'b1, B+8,  32'h2, 1, 0, 32'h0,         2});
    vecs.push_back('{0, 0,            1'b0, B+4,  0,     1, 1, 32'h0000_0200, 2});
    vecs.push_back('{0, 0,            1'b0, B+12, 0,     0, 0, 32'h0,         2});
    vecs.push_back('{0, 0,            1'b0, 32'h3000_0000, 0, 0, 0, 32'h0,    2});
    vecs.push_back('{0, 0,            1'b1, B+8,  32'h1, 1, 0, 32'h0,         0});
    vecs.push_back('{0, 0,            1'b0, B,    0,     1, 1, 32'h0,         0});
    vecs.push_back('{0, 0,            1'b1, B+8,  32'h1, 1, 0, 32'h0,         0});
    vecs.push_back('{0, 0,            1'b0, B+4,  0,     1, 1, 32'h5,         0});
    vecs.push_back('{0, 0,            1'b0, B+4,  0,     1, 1, 32'h1,         0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst count", 32'(count), 32'h0);
    chk("rst empty", {31'b0, empty}, 32'h1);
    chk("rst res_ready", {31'b0, res_ready}, 32'h1);
    chk("rst ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("rst dat", wbs_dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single accesses
    foreach (vecs[i]) begin
      if (vecs[i].npush > 0) push_words(vecs[i].npush, vecs[i].pbase);
      bus(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd, a1, a2);
      chk($sformatf("vec%0d ack", i), {31'b0, a1}, {31'b0, vecs[i].exp_ack});
      chk($sformatf("vec%0d ack pulse", i), {31'b0, a2}, 32'h0);
      if (vecs[i].chk_dat) chk($sformatf("vec%0d data", i), rd, vecs[i].exp_dat);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_cnt));
    end

    // Fill with res_valid held for 10 cycles
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = 32'hB000_0000 + 32'(k);
      r = res_ready;
      @(posedge clk);
      if (r) k++;
    end
    @(negedge clk);
    res_valid = 1'b0;
    chk("fill accepts", 32'(k), 32'd8);
    chk("fill count", 32'(count), 32'd8);
    chk("fill res_ready", {31'b0, res_ready}, 32'h0);
    rd_chk("full status", B+4, 32'h0000_0802);
    rd_chk("full pop", B, 32'hB000_0000);
    chk("ready after pop", {31'b0, res_ready}, 32'h1);
    push_words(1, 32'hB000_0008);
    chk("refill count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("wrap pop%0d", i), B, 32'hB000_0001 + 32'(i));
    end
    chk("drained empty", {31'b0, empty}, 32'h1);

    // Held strobe: one ack every two cycles, no double pop
    push_words(2, 32'hD000_0000);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = B;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (wbs_ack_o) acks++;
    end
    chk("held stb data", wbs_dat_o, 32'hD000_0001);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("held stb acks", 32'(acks), 32'd2);
    chk("held stb count", 32'(count), 32'd0);

    // Push and pop on the same edge
    push_words(1, 32'hC000_0000);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = B;
    res_valid = 1'b1; res_data = 32'hC000_0001;
    @(posedge clk);
    #1;
    chk("pushpop data", wbs_dat_o, 32'hC000_0000);
    chk("pushpop count", 32'(count), 32'd1);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; res_valid = 1'b0;
    @(posedge clk);
    rd_chk("pushpop next", B, 32'hC000_0001);

    // Flush on the same edge as a push
    push_words(5, 32'hE000_0000);
    chk("preflush count", 32'(count), 32'd5);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = B+8; wbs_dat_i = 32'h1;
    res_valid = 1'b1; res_data = 32'hE000_00FF;
    @(posedge clk);
    #1;
    chk("flush ack", {31'b0, wbs_ack_o}, 32'h1);
    chk("flush count", 32'(count), 32'd0);
    chk("flush empty", {31'b0, empty}, 32'h1);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_dat_i = '0; res_valid = 1'b0;
    @(posedge clk);
    push_words(1, 32'hF000_0000);
    rd_chk("post flush pop", B, 32'hF000_0000);

    // Reset during the ACK cycle
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = B+4;
    @(posedge clk);
    #1;
    chk("pre-rst ack", {31'b0, wbs_ack_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst ack drop", {31'b0, wbs_ack_o}, 32'h0);
    chk("rst count", 32'(count), 32'd0);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("no late ack", {31'b0, wbs_ack_o}, 32'h0);
    rd_chk("post rst status", B+4, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_output_fifo.md
Name: nn_output_fifo

Overview:
- Result-side buffer of the Wishbone neural-net peripheral; mirror of the input FIFO.
- The NN core pushes 32-bit results over a valid/ready handshake.
- The Wishbone host drains the results through a memory-mapped responder: a DATA read pops one entry, STATUS reports fill level and flags, CTRL flushes the buffer.
- Sits between the NN core output and the Wishbone slave bus mux.

Parameters:
DEPTH, 8, number of 32-bit entries; power of two, minimum 2
BASE_ADDR, 32'h3000_0100, word-aligned base of the 3-register window

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
res_valid  input  1  NN core offers a result
res_data  input  32  result word
res_ready  output  1  FIFO accepts a result; combinational, equals count < DEPTH
wbs_cyc_i  input  1  Wishbone cycle
wbs_stb_i  input  1  Wishbone strobe
wbs_we_i  input  1  Wishbone write enable
wbs_adr_i  input  32  Wishbone byte address
wbs_dat_i  input  32  Wishbone write data
wbs_dat_o  output  32  Wishbone read data; registered
wbs_ack_o  output  1  Wishbone acknowledge; registered, one-cycle pulse
empty  output  1  count == 0
count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH

Behaviour:
- Reset (async, rst=1):
  - count=0, read/write pointers=0, underflow=0, FSM=IDLE.
  - wbs_ack_o=0, wbs_dat_o=0, empty=1, res_ready=1.
  - Storage contents are don't-care.
- Pointers: $clog2(DEPTH) bits wide; wrap naturally from DEPTH-1 to 0.
- count: one bit wider than the pointers so DEPTH is representable; full is count==DEPTH.
- Push: occurs on a clock edge when res_valid && res_ready. res_data is written at wptr, wptr increments, count increments. Data is readable by the next DATA access.
- Register map (word offsets from BASE_ADDR):
  - +0x0 DATA (R): returns the entry at rptr and pops it. Writes are acked and ignored.
  - +0x4 STATUS (R): bit0 empty, bit1 full, bit2 underflow, bits[15:8] count zero-extended, other bits 0. Reading STATUS clears underflow. Writes are acked and ignored.
  - +0x8 CTRL (W): bit0=1 flushes (pointers and count to 0; underflow is not cleared). Reads return 0.
  - Any other address: no ack; the FSM stays IDLE.
- FSM, states IDLE and ACK:
  - IDLE -> ACK on wbs_cyc_i && wbs_stb_i && a decoded address. On that edge wbs_dat_o is loaded and any side effect (pop, flush, underflow clear) happens.
  - ACK: wbs_ack_o=1 for exactly this one cycle, then unconditionally back to IDLE.
  - In ACK the strobe is ignored, so a held strobe produces one ack every 2 cycles and never a double pop.
- Read latency: ack and data appear on the cycle after the strobe is first seen in IDLE.
- DATA read when count==0: wbs_dat_o=0, pointers unchanged, underflow set to 1, ack still given.
- Simultaneous push and pop on the same edge: both pointers advance and count is unchanged. When count==DEPTH, res_ready=0, so a push cannot coincide with a pop from full.
- Simultaneous push and flush: flush wins and the pushed word is discarded; count=0 afterwards.
- STATUS read on the same edge as a push: reports the count before that edge.
- rst asserted mid-transaction: the FSM returns to IDLE and a pending ack is dropped. The master must retry.
- wbs_dat_o holds its last value between acks.

Decomposition:
- Package nn_wb_pkg holds:
  - register offset constants OFF_DATA=0, OFF_STATUS=4, OFF_CTRL=8;
  - STATUS bit-index constants;
  - typedef wb_state_t {IDLE, ACK}.
- One sub-module, nn_sync_fifo: storage, pointers, count, push/pop/flush; no bus logic.
- nn_output_fifo wraps nn_sync_fifo with address decode, the FSM and the underflow flag.

Test Plan:
- Reset, then read STATUS -> ack exactly 1 cycle after the strobe; data=32'h0000_0001 (empty=1, count=0).
- Push 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, then 3 DATA reads -> the same values in order; final STATUS=32'h0000_0001.
- Push 8 words with res_valid held high for 10 cycles -> res_ready drops after the 8th accept, count=8. STATUS read -> 32'h0000_0802.
- From full, one DATA read -> res_ready=1 the next cycle. 9th word accepted; count returns to 8. Read order shows rptr wrapping 7->0.
- DATA read when empty -> data 0, ack given. STATUS read -> bit2=1; a second STATUS read -> bit2=0.
- Write CTRL=1 with count=5 while res_valid=1 on the same edge -> count=0 and empty=1. Assert rst during an ACK cycle -> ack drops immediately and count stays 0.
